avr_dbus_responder: RTL and testbench

//  Responder for the CPU data bus (address/wb/w out, din_raw in). Decodes each access to SRAM or I/O.
//  I/O space holds PORTB/DDRB/PINB and a UART transmitter with a TX FIFO.

---
 rtl/avr_dbus_pkg.sv | 32 +++
 rtl/avr_uart_tx.sv | 125 ++++++++++++
 rtl/avr_dbus_responder.sv | 95 +++++++++
 tb/tb_avr_dbus_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/avr_dbus_pkg.sv
// avr_dbus_pkg: shared address map, region decode and TX state encoding
package avr_dbus_pkg;

    localparam logic [15:0] ADDR_PINB  = 16'h0036;
    localparam logic [15:0] ADDR_DDRB  = 16'h0037;
    localparam logic [15:0] ADDR_PORTB = 16'h0038;
    localparam logic [15:0] ADDR_UBRR  = 16'h0029;
    localparam logic [15:0] ADDR_UCSRB = 16'h002A;
    localparam logic [15:0] ADDR_UCSRA = 16'h002B;
    localparam logic [15:0] ADDR_UDR   = 16'h002C;

    localparam logic [15:0] IO_BASE  = 16'h0020;
    localparam logic [15:0] RAM_BASE = 16'h0060;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_IO,
        REG_RAM
    } region_e;

    function automatic region_e decode(input logic [15:0] a);
        return a >= RAM_BASE ? REG_RAM : a >= IO_BASE ? REG_IO : REG_NONE;
    endfunction

endpackage

// File: rtl/avr_uart_tx.sv
// avr_uart_tx: 8N1 transmitter fed from a small TX FIFO
module avr_uart_tx
    import avr_dbus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic [7:0] ubrr,
    output logic       udre,
    output logic       txc_set,
    output logic       tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    tx_state_e     state_q;
    logic [7:0]    bcnt_q, per_q, shift_q;
    logic [2:0]    bit_q;
    logic          tx_q;
    logic          full, empty, push_ok, tick, pop;

    assign full    = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty   = count_q == '0;
    assign udre    = !full;
    assign push_ok = push && !full;
    // bit period ends when the counter reaches the period latched at the last reload
    assign tick    = bcnt_q == per_q;
    assign pop     = !empty && (state_q == TX_IDLE || (state_q == TX_STOP && tick));
    assign txc_set = state_q == TX_STOP && tick && empty;
    assign tx      = tx_q;

    // FIFO storage, no reset needed since pointers define validity
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        end
    end

    // frame sequencer with registered serial output
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TX_IDLE;
            tx_q    <= 1'b1;
            bcnt_q  <= '0;
            per_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= TX_START;
                        bcnt_q  <= '0;
                        per_q   <= ubrr;
                        tx_q    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        state_q <= TX_DATA;
                        bit_q   <= '0;
                        bcnt_q  <= '0;
                        per_q   <= ubrr;
                        tx_q    <= shift_q[0];
                    end else begin
                        bcnt_q <= bcnt_q + 8'd1;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        bcnt_q <= '0;
                        per_q  <= ubrr;
                        if (bit_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 8'd1;
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        bcnt_q <= '0;
                        per_q  <= ubrr;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= TX_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= TX_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 8'd1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/avr_dbus_responder.sv
// avr_dbus_responder: CPU data-bus decode to SRAM, PORTB block and UART TX
module avr_dbus_responder
    import avr_dbus_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] UBRR_RESET = 8'd0,
    parameter int         PIN_SYNC   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  wb,
    input  logic        w,
    output logic [7:0]  din_raw,
    output logic [15:0] ram_address,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  ram_wb,
    output logic        ram_w,
    output logic        uart_tx,
    output logic [7:0]  port_b,
    output logic [7:0]  ddr_b,
    input  logic [7:0]  pin_b,
    output logic        irq_udre
);

    region_e    region, sel_q;
    logic [7:0] ddr_q, portb_q, ubrr_q, ucsrb_q, io_q, io_d, pinb;
    logic [7:0] sync_q [PIN_SYNC];
    logic       txc_q, io_wr, udr_push, udre, txc_set;

    assign region      = decode(address);
    assign io_wr       = w && region == REG_IO;
    assign udr_push    = io_wr && address == ADDR_UDR;
    assign ram_address = address;
    assign ram_wb      = wb;
    assign ram_w       = w && address >= RAM_BASE;
    assign port_b      = portb_q & ddr_q;
    assign ddr_b       = ddr_q;
    assign irq_udre    = udre && ucsrb_q[5];
    assign pinb        = sync_q[PIN_SYNC-1];
    // SRAM already has a one-cycle read latency, so only I/O data is registered here
    assign din_raw     = sel_q == REG_RAM ? ram_dout : io_q;

    // I/O read mux for the current address
    always_comb begin
        io_d = '0;
        if (region == REG_IO)
            io_d = address == ADDR_PINB  ? pinb :
                   address == ADDR_DDRB  ? ddr_q :
                   address == ADDR_PORTB ? portb_q :
                   address == ADDR_UBRR  ? ubrr_q :
                   address == ADDR_UCSRB ? ucsrb_q :
                   address == ADDR_UCSRA ? {1'b0, txc_q, udre, 5'b0} : 8'h00;
    end

    // pin input synchronizer
    always_ff @(posedge clock) begin
        for (int i = 0; i < PIN_SYNC; i++) sync_q[i] <= reset ? 8'h00 : i == 0 ? pin_b : sync_q[i == 0 ? 0 : i-1];
    end

    // I/O register writes and registered read path
    always_ff @(posedge clock) begin
        if (reset) begin
            ddr_q   <= '0;
            portb_q <= '0;
            ubrr_q  <= UBRR_RESET;
            ucsrb_q <= '0;
            txc_q   <= 1'b0;
            sel_q   <= REG_NONE;
            io_q    <= '0;
        end else begin
            if (io_wr && address == ADDR_DDRB) ddr_q <= wb;
            if (io_wr && address == ADDR_PORTB) portb_q <= wb;
            if (io_wr && address == ADDR_UBRR) ubrr_q <= wb;
            if (io_wr && address == ADDR_UCSRB) ucsrb_q <= wb;
            txc_q <= txc_set || (txc_q && !(io_wr && address == ADDR_UCSRA && wb[6]));
            sel_q <= region;
            io_q  <= io_d;
        end
    end

    avr_uart_tx #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_tx (
        .clock    (clock),
        .reset    (reset),
        .push     (udr_push),
        .push_data(wb),
        .ubrr     (ubrr_q),
        .udre     (udre),
        .txc_set  (txc_set),
        .tx       (uart_tx)
    );

endmodule

// File: tb/tb_avr_dbus_responder.sv
// tb_avr_dbus_responder: randomized and directed checks against a frame-level reference model
module tb_avr_dbus_responder;

    localparam int DEPTH = 4;
    localparam int PS    = 2;

    logic        clock, reset, w, ram_w, uart_tx, irq_udre;
    logic [15:0] address, ram_address;
    logic [7:0]  wb, din_raw, ram_dout, ram_wb, port_b, ddr_b, pin_b;

    avr_dbus_responder #(
        .FIFO_DEPTH(DEPTH),
        .UBRR_RESET(8'd0),
        .PIN_SYNC  (PS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .wb         (wb),
        .w          (w),
        .din_raw    (din_raw),
        .ram_address(ram_address),
        .ram_dout   (ram_dout),
        .ram_wb     (ram_wb),
        .ram_w      (ram_w),
        .uart_tx    (uart_tx),
        .port_b     (port_b),
        .ddr_b      (ddr_b),
        .pin_b      (pin_b),
        .irq_udre   (irq_udre)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // synchronous SRAM stand-in, read-before-write
    logic [7:0] sram [0:65535];
    initial for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
    always @(posedge clock) begin
        if (ram_w) sram[ram_address] <= ram_wb;
        ram_dout <= sram[ram_address];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [7:0] ref_mem [0:65535];
    initial for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    logic [7:0] m_ddr, m_port, m_ubrr, m_ucsrb, m_rd, m_cur;
    logic       m_txc, m_busy;
    logic [7:0] m_pin [PS];
    logic [7:0] q [$];
    int         m_rem, m_len, m_per;

    function automatic logic [7:0] io_read(input logic [15:0] a);
        case (a)
            16'h0036: return m_pin[PS-1];
            16'h0037: return m_ddr;
            16'h0038: return m_port;
            16'h0029: return m_ubrr;
            16'h002A: return m_ucsrb;
            16'h002B: return {1'b0, m_txc, q.size() < DEPTH, 5'b0};
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic exp_tx();
        int idx;
        if (!m_busy) return 1'b1;
        idx = (m_len - m_rem) / m_per;
        return idx == 0 ? 1'b0 : idx == 9 ? 1'b1 : m_cur[idx-1];
    endfunction

    task automatic model_edge(input logic [15:0] a, input logic [7:0] d, input logic wr, input logic rst);
        logic pop, txc_s, acc;
        if (rst) begin
            m_ddr = 0; m_port = 0; m_ubrr = 0; m_ucsrb = 0; m_txc = 0; m_rd = 0;
            m_busy = 0; m_rem = 0; q.delete();
            for (int i = 0; i < PS; i++) m_pin[i] = 0;
            return;
        end
        m_rd = a >= 16'h0060 ? ref_mem[a] : a >= 16'h0020 ? io_read(a) : 8'h00;
        pop = 0; txc_s = 0;
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                if (q.size() > 0) pop = 1;
                else begin m_busy = 0; txc_s = 1; end
            end
        end else if (q.size() > 0) pop = 1;
        acc = wr && a == 16'h002C && q.size() < DEPTH;
        if (pop) begin
            m_cur = q.pop_front();
            m_busy = 1;
            m_per = m_ubrr + 1;
            m_len = 10 * m_per;
            m_rem = m_len;
        end
        if (acc) q.push_back(d);
        if (wr && a == 16'h0037) m_ddr = d;
        if (wr && a == 16'h0038) m_port = d;
        if (wr && a == 16'h0029) m_ubrr = d;
        if (wr && a == 16'h002A) m_ucsrb = d;
        m_txc = txc_s || (m_txc && !(wr && a == 16'h002B && d[6]));
        if (wr && a >= 16'h0060) ref_mem[a] = d;
        for (int i = PS-1; i > 0; i--) m_pin[i] = m_pin[i-1];
        m_pin[0] = pin_b;
    endtask

    task automatic tick(input logic [15:0] a, input logic [7:0] d, input logic wr);
        address = a; wb = d; w = wr;
        @(posedge clock);
        model_edge(a, d, wr, reset);
        @(negedge clock);
        check("uart_tx", uart_tx, exp_tx());
        check("irq_udre", irq_udre, q.size() < DEPTH && m_ucsrb[5]);
        check("din_raw", din_raw, m_rd);
        check("port_b", port_b, m_port & m_ddr);
        check("ddr_b", ddr_b, m_ddr);
        check("ram_w", ram_w, wr && a >= 16'h0060);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(16'h0000, 8'h00, 1'b0);
    endtask

    initial begin
        logic [15:0] a;
        int r;
        reset = 1'b1; pin_b = 8'h00;
        idle(2);
        reset = 1'b0;
        // reset state reads
        tick(16'h0037, 8'h00, 1'b0);
        check("rst_ddrb", din_raw, 8'h00);
        tick(16'h0038, 8'h00, 1'b0);
        check("rst_portb", din_raw, 8'h00);
        tick(16'h002B, 8'h00, 1'b0);
        check("rst_ucsra", din_raw, 8'h20);
        check("rst_tx", uart_tx, 1'b1);
        // SRAM write/readback and none-region write
        tick(16'h0100, 8'hA5, 1'b1);
        tick(16'h0100, 8'h00, 1'b0);
        check("sram_rd", din_raw, 8'hA5);
        tick(16'h0010, 8'h7E, 1'b1);
        tick(16'h0010, 8'h00, 1'b0);
        check("none_rd", din_raw, 8'h00);
        // single frame at UBRR=3
        tick(16'h0029, 8'd3, 1'b1);
        tick(16'h002C, 8'h55, 1'b1);
        idle(45);
        tick(16'h002B, 8'h00, 1'b0);
        check("txc_set", din_raw, 8'h60);
        tick(16'h002B, 8'h40, 1'b1);
        tick(16'h002B, 8'h00, 1'b0);
        check("txc_clr", din_raw, 8'h20);
        // back-to-back pushes at UBRR=0, overflow drop
        tick(16'h0029, 8'd0, 1'b1);
        tick(16'h002A, 8'h20, 1'b1);
        for (int i = 1; i <= 6; i++) tick(16'h002C, 8'(i), 1'b1);
        check("udre_full", irq_udre, 1'b0);
        idle(60);
        // port and pin synchronizer
        tick(16'h0037, 8'h0F, 1'b1);
        tick(16'h0038, 8'hFF, 1'b1);
        check("portb_mask", port_b, 8'h0F);
        pin_b = 8'h3C;
        for (int i = 0; i < 5; i++) tick(16'h0036, 8'h00, 1'b0);
        check("pinb_sync", din_raw, 8'h3C);
        // reset mid-frame then a clean frame
        tick(16'h0029, 8'd2, 1'b1);
        tick(16'h002C, 8'hA3, 1'b1);
        idle(12);
        reset = 1'b1;
        tick(16'h0000, 8'h00, 1'b0);
        check("rst_mid_tx", uart_tx, 1'b1);
        reset = 1'b0;
        tick(16'h002B, 8'h00, 1'b0);
        check("rst_mid_udre", din_raw, 8'h20);
        tick(16'h002C, 8'hC6, 1'b1);
        idle(15);
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) pin_b = 8'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin
                    a = 16'h0020 + 16'($urandom_range(0, 63));
                    tick(a, 8'h00, 1'b0);
                end
                2: tick($urandom_range(0, 1) ? 16'h0037 : 16'h0038, 8'($urandom), 1'b1);
                3: tick(16'h002A, 8'($urandom), 1'b1);
                4: tick(16'h002C, 8'($urandom), 1'b1);
                5: tick(16'h002B, 8'($urandom), 1'b1);
                6: tick(16'h0060 + 16'($urandom_range(0, 15)), 8'($urandom), 1'b1);
                7: tick(16'h0060 + 16'($urandom_range(0, 15)), 8'h00, 1'b0);
                8: tick(16'($urandom_range(0, 31)), 8'($urandom), $urandom_range(0, 1) == 1);
                default: begin
                    if (!m_busy && q.size() == 0) tick(16'h0029, 8'($urandom_range(0, 2)), 1'b1);
                    else tick(16'h0029, 8'h00, 1'b0);
                end
            endcase
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
